// File: rtl/keyboard_decoder.sv
// ----------------------------------------------------------------------------
// keyboard_decoder
//   PS/2 keyboard front end. Synchronises and glitch-filters the PS/2 pins,
//   deframes 11-bit scancode frames, tracks break (F0) / extended (E0)
//   prefixes, maps the make codes of W/A/S/D/SPACE/Z to 3-bit ops and offers
//   them to the game logic through a one-entry ready/read_fin handshake.
//
// Ports
//   clock              in   system clock, all logic on posedge
//   reset              in   asynchronous, active-high reset
//   ps2_clock          in   raw PS/2 clock pin (asynchronous)
//   ps2_data           in   raw PS/2 data pin (asynchronous)
//   keyboard_read_fin  in   consumer has taken keyboard_data
//   keyboard_ready     out  keyboard_data holds an unconsumed op
//   keyboard_data      out  op: W=000 A=001 S=010 D=011 SPACE=100 Z=101
// ----------------------------------------------------------------------------
module keyboard_decoder #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ps2_clock,
    input  logic       ps2_data,
    input  logic       keyboard_read_fin,
    output logic       keyboard_ready,
    output logic [2:0] keyboard_data
);

    localparam int FILT_W = $clog2(FILTER_LEN + 1);
    localparam int TMO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(FILTER_LEN - 1);
    localparam logic [TMO_W-1:0]  TMO_MAX   = TMO_W'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_RECV  = 2'd1,
        RX_CHECK = 2'd2
    } rx_state_t;

    // Make-code lookup: returns {valid, op}.
    function automatic logic [3:0] map_make(input logic [7:0] code);
        case (code)
            8'h1D:   map_make = 4'b1_000;
            8'h1C:   map_make = 4'b1_001;
            8'h1B:   map_make = 4'b1_010;
            8'h23:   map_make = 4'b1_011;
            8'h29:   map_make = 4'b1_100;
            8'h1A:   map_make = 4'b1_101;
            default: map_make = 4'b0_000;
        endcase
    endfunction

    logic              clk_s1_q, clk_s1_d, clk_s2_q, clk_s2_d;
    logic              dat_s1_q, dat_s1_d, dat_s2_q, dat_s2_d;
    logic              filt_q, filt_d;
    logic [FILT_W-1:0] fcnt_q, fcnt_d;
    rx_state_t         state_q, state_d;
    logic [3:0]        bit_cnt_q, bit_cnt_d;
    logic [8:0]        shift_q, shift_d;
    logic              stop_q, stop_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic              break_q, break_d, ext_q, ext_d;
    logic              ready_q, ready_d;
    logic [2:0]        data_q, data_d;

    logic       fall;
    logic       frame_ok, frame_bad;
    logic       op_vld;
    logic [2:0] op;
    logic [3:0] lookup;

    always_comb begin
        // Two-flop synchronisers; idle PS/2 lines are high.
        clk_s1_d = ps2_clock;
        clk_s2_d = clk_s1_q;
        dat_s1_d = ps2_data;
        dat_s2_d = dat_s1_q;

        // Glitch filter: a new clock level must be seen FILTER_LEN
        // consecutive cycles before the filtered clock follows it.
        filt_d = filt_q;
        fcnt_d = '0;
        fall   = 1'b0;
        if (clk_s2_q != filt_q) begin
            if (fcnt_q == FILT_LAST) begin
                filt_d = clk_s2_q;
                fall   = filt_q;
            end else begin
                fcnt_d = fcnt_q + FILT_W'(1);
            end
        end

        // Receiver: shift start-stripped frame, data LSB first then parity.
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        stop_d    = stop_q;
        tmo_d     = '0;
        case (state_q)
            RX_IDLE: begin
                if (fall && !dat_s2_q) begin
                    state_d   = RX_RECV;
                    bit_cnt_d = 4'd0;
                end
            end
            RX_RECV: begin
                if (fall) begin
                    if (bit_cnt_q == 4'd9) begin
                        stop_d  = dat_s2_q;
                        state_d = RX_CHECK;
                    end else begin
                        shift_d   = {dat_s2_q, shift_q[8:1]};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end else if (tmo_q == TMO_MAX) begin
                    // Stalled frame: drop it and wait for a new start bit.
                    state_d = RX_IDLE;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            RX_CHECK: state_d = RX_IDLE;
            default:  state_d = RX_IDLE;
        endcase

        // Odd parity: data bits plus parity bit must XOR to 1.
        frame_ok  = (state_q == RX_CHECK) && (^shift_q) && stop_q;
        frame_bad = (state_q == RX_CHECK) && !frame_ok;

        // Prefix tracking: the byte following F0 or E0 is swallowed.
        break_d = break_q;
        ext_d   = ext_q;
        op_vld  = 1'b0;
        op      = 3'b000;
        lookup  = map_make(shift_q[7:0]);
        if (frame_bad) begin
            break_d = 1'b0;
            ext_d   = 1'b0;
        end else if (frame_ok) begin
            if (shift_q[7:0] == 8'hF0) begin
                break_d = 1'b1;
            end else if (shift_q[7:0] == 8'hE0) begin
                ext_d = 1'b1;
            end else if (break_q || ext_q) begin
                break_d = 1'b0;
                ext_d   = 1'b0;
            end else begin
                op_vld = lookup[3];
                op     = lookup[2:0];
            end
        end

        // One-entry handshake: while an op is pending, new ops are dropped,
        // and a read_fin in the same cycle as a new op still only clears.
        ready_d = ready_q;
        data_d  = data_q;
        if (ready_q) begin
            if (keyboard_read_fin) begin
                ready_d = 1'b0;
            end
        end else if (op_vld) begin
            ready_d = 1'b1;
            data_d  = op;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            clk_s1_q  <= 1'b1;
            clk_s2_q  <= 1'b1;
            dat_s1_q  <= 1'b1;
            dat_s2_q  <= 1'b1;
            filt_q    <= 1'b1;
            fcnt_q    <= '0;
            state_q   <= RX_IDLE;
            bit_cnt_q <= 4'd0;
            shift_q   <= 9'd0;
            stop_q    <= 1'b0;
            tmo_q     <= '0;
            break_q   <= 1'b0;
            ext_q     <= 1'b0;
            ready_q   <= 1'b0;
            data_q    <= 3'b000;
        end else begin
            clk_s1_q  <= clk_s1_d;
            clk_s2_q  <= clk_s2_d;
            dat_s1_q  <= dat_s1_d;
            dat_s2_q  <= dat_s2_d;
            filt_q    <= filt_d;
            fcnt_q    <= fcnt_d;
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            stop_q    <= stop_d;
            tmo_q     <= tmo_d;
            break_q   <= break_d;
            ext_q     <= ext_d;
            ready_q   <= ready_d;
            data_q    <= data_d;
        end
    end

    assign keyboard_ready = ready_q;
    assign keyboard_data  = data_q;

endmodule

// File: tb/tb_keyboard_decoder.sv
// ----------------------------------------------------------------------------
// tb_keyboard_decoder
//   Directed bench for keyboard_decoder: a table of single frames with
//   expected ready/data, plus hand-written sequences for latency, hold,
//   drop-while-busy, clear-wins, timeout, glitch and async reset.
// ----------------------------------------------------------------------------
module tb_keyboard_decoder;

    localparam int FLEN = 8;
    localparam int TMO  = 300;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       ps2_clock = 1'b1;
    logic       ps2_data = 1'b1;
    logic       keyboard_read_fin = 1'b0;
    logic       keyboard_ready;
    logic [2:0] keyboard_data;

    int n_chk  = 0;
    int n_fail = 0;

    keyboard_decoder #(
        .FILTER_LEN    (FLEN),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .ps2_clock        (ps2_clock),
        .ps2_data         (ps2_data),
        .keyboard_read_fin(keyboard_read_fin),
        .keyboard_ready   (keyboard_ready),
        .keyboard_data    (keyboard_data)
    );

    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish required finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [7:0] code;
        bit         par_ok;
        bit         stop_b;
        bit         exp_rdy;
        logic [2:0] exp_data;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    // One PS/2 bit: data set mid-high, clock low 20 cycles, high 10 more.
    task automatic send_bit(input logic b);
        ps2_data = b;
        wait_cyc(10);
        ps2_clock = 1'b0;
        wait_cyc(20);
        ps2_clock = 1'b1;
        wait_cyc(10);
    endtask

    // Start bit, 8 data bits LSB first, parity (odd unless par_ok=0).
    task automatic send_head(input logic [7:0] b, input bit par_ok);
        logic par;
        par = ~(^b) ^ ~par_ok;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(par);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit par_ok, input bit stop_b);
        send_head(b, par_ok);
        send_bit(stop_b);
        ps2_data = 1'b1;
        wait_cyc(10);
    endtask

    task automatic clear_ready(input string name, input logic [2:0] exp_data);
        keyboard_read_fin = 1'b1;
        @(negedge clock);
        keyboard_read_fin = 1'b0;
        chk({name, "_clr_rdy"}, {31'd0, keyboard_ready}, 32'd0);
        chk({name, "_clr_data"}, {29'd0, keyboard_data}, {29'd0, exp_data});
    endtask

    vec_t vecs[$];

    initial begin
        vecs.push_back('{8'h1D, 1, 1, 1, 3'b000});
        vecs.push_back('{8'h1C, 1, 1, 1, 3'b001});
        vecs.push_back('{8'h1B, 1, 1, 1, 3'b010});
        vecs.push_back('{8'h23, 1, 1, 1, 3'b011});
        vecs.push_back('{8'h29, 1, 1, 1, 3'b100});
        vecs.push_back('{8'h1A, 1, 1, 1, 3'b101});
        vecs.push_back('{8'h55, 1, 1, 0, 3'b101});
        vecs.push_back('{8'hF0, 1, 1, 0, 3'b101});
        vecs.push_back('{8'h1C, 1, 1, 0, 3'b101});
        vecs.push_back('{8'h1C, 1, 1, 1, 3'b001});
        vecs.push_back('{8'hE0, 1, 1, 0, 3'b001});
        vecs.push_back('{8'h75, 1, 1, 0, 3'b001});
        vecs.push_back('{8'h1D, 1, 1, 1, 3'b000});
        vecs.push_back('{8'hF0, 1, 1, 0, 3'b000});
        vecs.push_back('{8'h1B, 0, 1, 0, 3'b000});
        vecs.push_back('{8'h1C, 1, 1, 1, 3'b001});
        vecs.push_back('{8'h23, 0, 1, 0, 3'b001});
        vecs.push_back('{8'h1A, 1, 0, 0, 3'b001});
        vecs.push_back('{8'h1A, 1, 1, 1, 3'b101});

        // Reset state
        wait_cyc(4);
        chk("reset_rdy", {31'd0, keyboard_ready}, 32'd0);
        chk("reset_data", {29'd0, keyboard_data}, 32'd0);
        reset = 1'b0;
        wait_cyc(20);

        // 0x1D: ready exactly two clocks after the filtered stop-bit edge
        send_head(8'h1D, 1);
        ps2_data = 1'b1;
        wait_cyc(10);
        ps2_clock = 1'b0;
        wait_cyc(10);
        chk("lat_before", {31'd0, keyboard_ready}, 32'd0);
        @(negedge clock);
        chk("lat_rdy", {31'd0, keyboard_ready}, 32'd1);
        chk("lat_data", {29'd0, keyboard_data}, 32'd0);
        wait_cyc(9);
        ps2_clock = 1'b1;
        wait_cyc(200);
        chk("hold_rdy", {31'd0, keyboard_ready}, 32'd1);
        chk("hold_data", {29'd0, keyboard_data}, 32'd0);

        // A arrives while W pending: dropped, not queued
        send_frame(8'h1C, 1, 1);
        chk("drop_rdy", {31'd0, keyboard_ready}, 32'd1);
        chk("drop_data", {29'd0, keyboard_data}, 32'd0);
        clear_ready("drop", 3'b000);
        wait_cyc(100);
        chk("drop_noq", {31'd0, keyboard_ready}, 32'd0);

        // SPACE after a clear
        send_frame(8'h29, 1, 1);
        chk("space_rdy", {31'd0, keyboard_ready}, 32'd1);
        chk("space_data", {29'd0, keyboard_data}, 32'd4);
        clear_ready("space", 3'b100);

        // Table of single frames
        foreach (vecs[i]) begin
            send_frame(vecs[i].code, vecs[i].par_ok, vecs[i].stop_b);
            wait_cyc(10);
            chk($sformatf("vec%0d_rdy", i), {31'd0, keyboard_ready}, {31'd0, vecs[i].exp_rdy});
            chk($sformatf("vec%0d_data", i), {29'd0, keyboard_data}, {29'd0, vecs[i].exp_data});
            if (vecs[i].exp_rdy) clear_ready($sformatf("vec%0d", i), vecs[i].exp_data);
        end

        // Timeout: start + 4 bits, then silence past the timeout
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        ps2_data = 1'b1;
        wait_cyc(TMO + 20);
        chk("tmo_rdy", {31'd0, keyboard_ready}, 32'd0);
        send_frame(8'h1B, 1, 1);
        chk("tmo_frame_rdy", {31'd0, keyboard_ready}, 32'd1);
        chk("tmo_frame_data", {29'd0, keyboard_data}, 32'd2);
        clear_ready("tmo", 3'b010);

        // read_fin in the very cycle a new op is decoded: clear wins
        send_frame(8'h1D, 1, 1);
        chk("cw_pre_rdy", {31'd0, keyboard_ready}, 32'd1);
        send_head(8'h23, 1);
        ps2_data = 1'b1;
        wait_cyc(10);
        ps2_clock = 1'b0;
        wait_cyc(10);
        keyboard_read_fin = 1'b1;
        @(negedge clock);
        keyboard_read_fin = 1'b0;
        chk("cw_clr", {31'd0, keyboard_ready}, 32'd0);
        wait_cyc(9);
        ps2_clock = 1'b1;
        wait_cyc(50);
        chk("cw_after_rdy", {31'd0, keyboard_ready}, 32'd0);
        chk("cw_after_data", {29'd0, keyboard_data}, 32'd0);

        // One-cycle low glitch on ps2_clock (with data low) is not a start bit
        ps2_data = 1'b0;
        ps2_clock = 1'b0;
        @(negedge clock);
        ps2_clock = 1'b1;
        wait_cyc(5);
        ps2_data = 1'b1;
        wait_cyc(50);
        chk("glitch_rdy", {31'd0, keyboard_ready}, 32'd0);
        send_frame(8'h23, 1, 1);
        chk("glitch_frame_rdy", {31'd0, keyboard_ready}, 32'd1);
        chk("glitch_frame_data", {29'd0, keyboard_data}, 32'd3);

        // Async reset mid-frame with D pending
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        ps2_clock = 1'b0;
        @(negedge clock);
        #2 reset = 1'b1;
        #1;
        chk("arst_rdy", {31'd0, keyboard_ready}, 32'd0);
        chk("arst_data", {29'd0, keyboard_data}, 32'd0);
        ps2_clock = 1'b1;
        ps2_data = 1'b1;
        wait_cyc(5);
        reset = 1'b0;
        wait_cyc(100);
        chk("arst_idle_rdy", {31'd0, keyboard_ready}, 32'd0);
        send_frame(8'h29, 1, 1);
        chk("arst_frame_rdy", {31'd0, keyboard_ready}, 32'd1);
        chk("arst_frame_data", {29'd0, keyboard_data}, 32'd4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
